// File: rtl/ysyx_24090012_lsu.sv
// ysyx_24090012_lsu: load/store unit between the EXU and a single-outstanding
// request/response data bus. Aligns store lanes, extends load data, and
// acknowledges every EXU request (memory or not) with a one-cycle mem_ready.
module ysyx_24090012_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] exu_to_lsu_inst,
  output logic        mem_ready,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  input  logic        bus_resp_err,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] lsu_load_cnt,
  output logic [31:0] lsu_store_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wen_q, wen_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cnt_ld_q, cnt_ld_d;
  logic        cnt_st_q, cnt_st_d;
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        is_load, is_store, f3_legal, misaligned;
  logic        unused_inst_bits;

  assign opcode   = exu_to_lsu_inst[6:0];
  assign funct3   = exu_to_lsu_inst[14:12];
  assign off      = mem_addr[1:0];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
  assign f3_legal = is_load ? (funct3 != 3'b011 && funct3[2:1] != 2'b11)
                            : (funct3[2] == 1'b0 && funct3[1:0] != 2'b11);
  assign misaligned = (funct3[1:0] == 2'b01 && off[0]) ||
                      (funct3[1:0] == 2'b10 && off != 2'b00);
  assign unused_inst_bits = ^{exu_to_lsu_inst[31:15], exu_to_lsu_inst[11:7]};

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] o);
    case (size)
      2'b00:   store_strb = 4'b0001 << o;
      2'b01:   store_strb = 4'b0011 << o;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                              input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> {o, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {24'b0, sh[7:0]};
      3'b101:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  // State register and all datapath/control flops, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wen_q       <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_ld_q    <= 1'b0;
      cnt_st_q    <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wen_q       <= wen_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_ld_q    <= cnt_ld_d;
      cnt_st_q    <= cnt_st_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // Next-state: only legal, aligned memory ops visit the bus states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mem_valid) begin
        if ((is_load || is_store) && f3_legal && !misaligned) state_d = S_REQ;
        else                                                  state_d = S_DONE;
      end
      S_REQ:  if (bus_req_ready)  state_d = S_WAIT;
      S_WAIT: if (bus_resp_valid) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from state, so bus inputs never reach mem_ready.
  always_comb begin
    mem_ready     = (state_q == S_DONE);
    bus_req_valid = (state_q == S_REQ);
  end

  // Datapath: latch the request on acceptance, the result on response,
  // and bump the matching counter on the way out of DONE.
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wen_d       = wen_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_ld_d    = cnt_ld_q;
    cnt_st_d    = cnt_st_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    case (state_q)
      S_IDLE: if (mem_valid) begin
        if (!(is_load || is_store)) begin
          err_d    = 1'b0;
          cnt_ld_d = 1'b0;
          cnt_st_d = 1'b0;
        end else if (!f3_legal || misaligned) begin
          err_d    = 1'b1;
          rdata_d  = '0;
          cnt_ld_d = 1'b0;
          cnt_st_d = 1'b0;
        end else begin
          addr_d   = {mem_addr[31:2], 2'b00};
          wen_d    = is_store;
          wstrb_d  = is_store ? store_strb(funct3[1:0], off) : 4'b0000;
          wdata_d  = mem_wdata << {off, 3'b000};
          funct3_d = funct3;
          off_d    = off;
          cnt_ld_d = is_load;
          cnt_st_d = is_store;
        end
      end
      S_WAIT: if (bus_resp_valid) begin
        rdata_d = wen_q ? 32'd0 : load_extend(funct3_q, off_q, bus_resp_rdata);
        err_d   = bus_resp_err;
      end
      S_DONE: begin
        if (cnt_ld_q) load_cnt_d  = load_cnt_q + 32'd1;
        if (cnt_st_q) store_cnt_d = store_cnt_q + 32'd1;
      end
      default: ;
    endcase
  end

  assign bus_req_addr  = addr_q;
  assign bus_req_wen   = wen_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_wstrb = wstrb_q;
  assign lsu_rdata     = rdata_q;
  assign lsu_err       = err_q;
  assign lsu_load_cnt  = load_cnt_q;
  assign lsu_store_cnt = store_cnt_q;

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Scoreboard bench for ysyx_24090012_lsu: the stimulus side plays the EXU and
// a reactive bus, pushing expected results; a negedge monitor pops and checks.
module tb_ysyx_24090012_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata, exu_to_lsu_inst;
  logic        mem_ready;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;
  logic        bus_resp_err;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic [31:0] lsu_load_cnt, lsu_store_cnt;

  always #5 clk = ~clk;

  ysyx_24090012_lsu dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .exu_to_lsu_inst(exu_to_lsu_inst), .mem_ready(mem_ready),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_err(bus_resp_err), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .lsu_load_cnt(lsu_load_cnt), .lsu_store_cnt(lsu_store_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
    logic [31:0] ld;
    logic [31:0] st;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];

  int unsigned cyc = 0;
  int checks = 0;
  int fails  = 0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] m_ld    = 32'd0;
  logic [31:0] m_st    = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: check bus requests against the head of the request queue and
  // every mem_ready against the head of the result queue.
  exp_t mon_e;
  req_t mon_r;
  exp_t post_e;
  logic post_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (post_pend) begin
        chk("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
        chk("rdata_held", lsu_rdata, post_e.rdata);
        chk("load_cnt", lsu_load_cnt, post_e.ld);
        chk("store_cnt", lsu_store_cnt, post_e.st);
      end
      post_pend <= 1'b0;
      if (bus_req_valid) begin
        if (req_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_req: bus_req_valid=1, expected 0 (addr %h)", bus_req_addr);
        end else begin
          mon_r = req_q[0];
          chk("req_addr", bus_req_addr, mon_r.addr);
          chk("req_wen", {31'd0, bus_req_wen}, {31'd0, mon_r.wen});
          chk("req_wstrb", {28'd0, bus_req_wstrb}, {28'd0, mon_r.wstrb});
          if (mon_r.wen) chk("req_wdata", bus_req_wdata, mon_r.wdata);
          if (bus_req_ready) void'(req_q.pop_front());
        end
      end
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_ready: mem_ready=1, expected 0");
        end else begin
          mon_e = exp_q.pop_front();
          chk("rdata", lsu_rdata, mon_e.rdata);
          chk("err", {31'd0, lsu_err}, {31'd0, mon_e.err});
          chk("ready_cycle", cyc, mon_e.cyc);
          post_e    <= mon_e;
          post_pend <= 1'b1;
        end
      end
    end
  end

  // Reference model: what the spec says one instruction should produce.
  task automatic run_op(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wd,
                        input int sr, input int sw, input logic [31:0] rb, input logic be);
    exp_t e;
    req_t r;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [1:0]  o;
    logic        is_ld, is_st, legal, mis, go_bus;
    logic [31:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    int lat;
    bit hs, seen, pre;
    int rc, wc;
    opc   = inst[6:0];
    f3    = inst[14:12];
    o     = addr[1:0];
    is_ld = (opc == 7'b0000011);
    is_st = (opc == 7'b0100011);
    legal = is_ld ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                  : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    mis   = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
    go_bus = 1'b0;
    if (!is_ld && !is_st) begin
      e.rdata = m_rdata; e.err = 1'b0; lat = 1;
    end else if (!legal || mis) begin
      e.rdata = 32'd0; e.err = 1'b1; lat = 1;
    end else begin
      go_bus = 1'b1;
      lat    = 3 + sr + sw;
      e.err  = be;
      sh     = rb >> (8 * o);
      case (f3)
        3'd0: begin sb = sh[7:0];   e.rdata = int'(sb);  end
        3'd1: begin shw = sh[15:0]; e.rdata = int'(shw); end
        3'd4: e.rdata = sh & 32'h0000_00FF;
        3'd5: e.rdata = sh & 32'h0000_FFFF;
        default: e.rdata = rb;
      endcase
      if (is_st) e.rdata = 32'd0;
      r.addr  = addr - 32'(o);
      r.wen   = is_st;
      r.wdata = wd << (8 * o);
      r.wstrb = !is_st ? 4'd0 : (f3 == 3'd0) ? 4'(1 << o) : (f3 == 3'd1) ? 4'(3 << o) : 4'hF;
      req_q.push_back(r);
      if (is_ld) m_ld = m_ld + 1; else m_st = m_st + 1;
    end
    m_rdata = e.rdata;
    e.ld  = m_ld;
    e.st  = m_st;
    e.cyc = cyc + lat;
    exp_q.push_back(e);

    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; exu_to_lsu_inst = inst;
    hs = 0; seen = 0; rc = 0; wc = 0;
    for (int n = 0; n < 100; n++) begin
      if (mem_ready) seen = 1;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
      bus_resp_rdata = $urandom;
      if (bus_req_valid && !hs) begin
        bus_req_ready = (rc >= sr);
        rc++;
      end
      if (hs && wc == sw) begin
        bus_resp_valid = 1'b1; bus_resp_rdata = rb; bus_resp_err = be;
      end else if ((!hs || wc > sw) && $urandom_range(3) == 0) begin
        bus_resp_valid = 1'b1; bus_resp_err = 1'($urandom_range(1));
      end
      if (hs) wc++;
      pre = bus_req_valid && bus_req_ready;
      @(posedge clk); #1;
      if (pre) hs = 1;
      if (seen) break;
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL timeout: mem_ready never seen for inst %h, expected at cycle %0d", inst, e.cyc);
    end
    if (!go_bus && hs) begin
      checks++; fails++;
      $display("FAIL bus_touched: handshake=1, expected 0 for inst %h", inst);
    end
    mem_valid = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_req_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("rst_req_addr", bus_req_addr, 32'd0);
    chk("rst_req_wdata", bus_req_wdata, 32'd0);
    chk("rst_req_wstrb", {28'd0, bus_req_wstrb}, 32'd0);
    chk("rst_req_wen", {31'd0, bus_req_wen}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_err", {31'd0, lsu_err}, 32'd0);
    chk("rst_load_cnt", lsu_load_cnt, 32'd0);
    chk("rst_store_cnt", lsu_store_cnt, 32'd0);
  endtask

  logic [31:0] rnd, inst, addr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  int k;
  bit got;

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; exu_to_lsu_inst = '0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0; bus_resp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals();

    // Directed cases from the test plan.
    run_op(32'h0010_0093, 32'h8000_0000, 32'h1234_5678, 0, 0, 32'h0, 1'b0);           // ADDI
    run_op(32'h0000_0023, 32'h8000_0003, 32'h0000_00AB, 0, 0, 32'h0, 1'b0);           // SB
    run_op(32'h0000_0003, 32'h8000_0002, 32'h0, 0, 0, 32'h0080_0000, 1'b0);           // LB
    run_op(32'h0000_4003, 32'h8000_0002, 32'h0, 0, 0, 32'h0080_0000, 1'b0);           // LBU
    run_op(32'h0000_5003, 32'h8000_0002, 32'h0, 0, 0, 32'hBEEF_0000, 1'b0);           // LHU
    run_op(32'h0000_2003, 32'h8000_0001, 32'h0, 0, 0, 32'h0, 1'b0);                   // LW misaligned
    run_op(32'h0010_0093, 32'h8000_0000, 32'h0, 0, 0, 32'h0, 1'b0);                   // rdata unchanged after fault
    run_op(32'h0000_2003, 32'h8000_0004, 32'h0, 3, 2, 32'hCAFE_F00D, 1'b1);           // LW stalled, bus error
    run_op(32'h0000_1023, 32'h8000_0006, 32'h0000_BEEF, 1, 1, 32'h0, 1'b0);           // SH upper half
    run_op(32'h0000_7003, 32'h8000_0000, 32'h0, 0, 0, 32'h0, 1'b0);                   // illegal load funct3
    run_op(32'h0000_3023, 32'h8000_0000, 32'h0, 0, 0, 32'h0, 1'b0);                   // illegal store funct3

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(9);
      rnd = $urandom;
      if (k < 2) begin
        do opc = 7'($urandom); while (opc == 7'b0000011 || opc == 7'b0100011);
        f3 = 3'($urandom);
      end else if (k < 6) begin
        opc = 7'b0000011;
        case ($urandom_range(4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else if (k < 9) begin
        opc = 7'b0100011;
        f3  = 3'($urandom_range(2));
      end else if (rnd[0]) begin
        opc = 7'b0000011;
        case ($urandom_range(2)) 0: f3 = 3'd3; 1: f3 = 3'd6; default: f3 = 3'd7; endcase
      end else begin
        opc = 7'b0100011;
        f3  = 3'($urandom_range(7, 3));
      end
      inst = {rnd[31:15], f3, rnd[11:7], opc};
      addr = $urandom;
      if ($urandom_range(1) == 0) addr = addr & 32'hFFFF_FFFC | 32'(f3[1:0] == 2'b10 ? 0 : (f3[1:0] == 2'b01 ? 2 * $urandom_range(1) : $urandom_range(3)));
      run_op(inst, addr, $urandom, $urandom_range(2), $urandom_range(2), $urandom,
             ($urandom_range(7) == 0));
    end

    // Reset while waiting for a load response; the late response must vanish.
    req_q.push_back('{addr: 32'h8000_0010, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    mem_valid = 1'b1; mem_addr = 32'h8000_0010; exu_to_lsu_inst = 32'h0000_2003;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      bus_req_ready = bus_req_valid;
      got = bus_req_valid;
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL rst_setup: bus_req_valid=0, expected 1");
    end
    bus_req_ready = 1'b0;
    rst = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_rdata = 32'hFFFF_FFFF; bus_resp_err = 1'b1;
    @(posedge clk); #1;
    bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
    m_rdata = 32'd0; m_ld = 32'd0; m_st = 32'd0;
    req_q.delete();
    repeat (3) @(posedge clk);
    #1 check_reset_vals();

    // Recovery after reset.
    run_op(32'h0000_2023, 32'h8000_0020, 32'h1122_3344, 0, 0, 32'h0, 1'b0);           // SW
    run_op(32'h0000_1003, 32'h8000_0022, 32'h0, 1, 0, 32'h8001_7FFF, 1'b0);           // LH negative
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0 || req_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL leftover: %0d results / %0d requests pending, expected 0", exp_q.size(), req_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
